bullet_hit_detector: RTL and testbench
======================================

Name: bullet_hit_detector

Overview:
Reads the bullet, enemy and player position/state vectors produced by the bullet generation/motion logic and resolves collisions once per game tick. A start pulse snapshots all inputs. A sequential scan then tests one candidate pair per clock and produces kill masks, bullet-consume masks and a player-hit flag. These masks are fed back to clear enemy and bullet state bits.

Parameters:
MAX_ENEMY, 15, number of enemies
MAX_ENEMY_BULLET_SET, 2, bullet slots per enemy
MAX_PLAYER_BULLET, 16, player bullet slots
BULLET_WIDTH, 6, bullet box width (px)
BULLET_HEIGHT, 20, bullet box height (px)
ENEMY_WIDTH, 36, enemy box width (px)
ENEMY_HEIGHT, 30, enemy box height (px)
PLAYER_WIDTH, 36, player box width (px)
PLAYER_HEIGHT, 30, player box height (px)

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  asynchronous active-low reset
i_Start  in  1  one-cycle scan request
i_EnemyState  in  MAX_ENEMY  alive mask
i_EnemyPos  in  19*MAX_ENEMY  flat positions, enemy n at [19n+18:19n]
i_EnemyBulletState  in  MAX_ENEMY*MAX_ENEMY_BULLET_SET  bit 2n+s = enemy n slot s active
i_EnemyBulletPos  in  19*MAX_ENEMY*MAX_ENEMY_BULLET_SET  flat, entry 2n+s
i_PlayerBulletState  in  MAX_PLAYER_BULLET  active mask
i_PlayerBulletPos  in  19*MAX_PLAYER_BULLET  flat positions
i_PlayerPos  in  19  player position
o_Busy  out  1  scan in progress
o_Done  out  1  one-cycle pulse, results valid
o_EnemyKill  out  MAX_ENEMY  enemies hit this scan
o_PlayerBulletConsume  out  MAX_PLAYER_BULLET  player bullets that hit
o_EnemyBulletConsume  out  MAX_ENEMY*MAX_ENEMY_BULLET_SET  enemy bullets that hit the player
o_PlayerHit  out  1  player hit this scan

Behaviour:
- Position format: [18:9] = X (10 b), [8:0] = Y (9 b), top-left corner of the box. The value 19'h7FFFF is don't-care and is only meaningful through the state bits.
- Reset: FSM in IDLE, all outputs 0, all index counters 0, all snapshot registers 0.
- FSM states: IDLE, SCAN_P, SCAN_E, DONE.
  - IDLE: i_Start=1 snapshots every input into registers, clears all result registers, and moves to SCAN_P with bullet idx=0 and enemy idx=0.
  - SCAN_P: evaluates pair (player bullet b, enemy e) each clock. e is the inner loop and b the outer loop, both ascending. After pair (MAX_PLAYER_BULLET-1, MAX_ENEMY-1) the FSM moves to SCAN_E with idx=0.
  - SCAN_E: evaluates enemy bullet k = 0 .. MAX_ENEMY*MAX_ENEMY_BULLET_SET-1 against the player, one per clock. After the last k the FSM moves to DONE.
  - DONE: o_Done=1 for exactly one cycle, then IDLE.
- o_Busy = 1 in SCAN_P and SCAN_E. o_Busy = 0 in IDLE and DONE.
- i_Start outside IDLE is ignored; a pulse arriving during DONE is not queued.
- Latency: o_Done is high in the cycle after the (P*E + E*S)th edge following the start-sampling edge, where P = MAX_PLAYER_BULLET, E = MAX_ENEMY, S = MAX_ENEMY_BULLET_SET. Defaults give 240 + 30 = 270 cycles. Latency is fixed regardless of hits.
- Overlap test (strict, unsigned, computed in 11 bits so nothing wraps): ax < bx+bw AND bx < ax+aw AND ay < by+bh AND by < ay+ah.
- SCAN_P hit condition: snapshot bullet b active, enemy e alive, b not yet consumed, e not yet killed, and the boxes overlap.
  - On a hit, set o_EnemyKill[e] and o_PlayerBulletConsume[b].
  - First match in scan order wins, so one bullet kills at most one enemy and one enemy consumes at most one bullet.
- SCAN_E hit condition: enemy bullet k active and overlaps the player box.
  - On a hit, set o_EnemyBulletConsume[k] and o_PlayerHit=1.
  - Every overlapping enemy bullet is consumed, not only the first.
- Result outputs update during the scan and must be sampled only on o_Done. They hold their value until the next accepted i_Start clears them.
- Inputs changing during a scan have no effect, because the scan uses only the snapshot.
- Reset asserted mid-scan: immediate return to IDLE with all outputs 0 and no o_Done pulse.

Test Plan:
1. Enemy 7 alive at (302,108), player bullet 0 active at (302,108), start pulse -> o_Busy high 270 cycles, o_Done after 270 cycles, o_EnemyKill=15'h0080, o_PlayerBulletConsume=16'h0001, o_PlayerHit=0.
2. Edge case: bullet 0 at (302,138) vs enemy 7 at (302,108) -> 138 < 108+30 is false, so no kill. Move the bullet to (302,137) -> kill of enemy 7.
3. Bullets 0 and 3 both at (302,108), enemy 7 alive -> o_EnemyKill=15'h0080, o_PlayerBulletConsume=16'h0001. Enemy 7 dead in snapshot -> both masks 0.
4. Enemy bullet entry 5 active at (302,372), entry 6 at (310,380), entry 7 inactive at (302,372), player at (302,372) -> o_PlayerHit=1, o_EnemyBulletConsume=30'h60.
5. Change the inputs and pulse i_Start at cycle 100 of a scan -> the start is ignored, results match the original snapshot, and o_Done occurs at cycle 270.
6. Assert i_Rst low at scan cycle 50 -> all outputs 0 at once, no o_Done. After release, a fresh start completes normally.

Source files
------------

// File: rtl/bullet_hit_detector.sv
// Per-tick collision resolver: snapshots bullet/enemy/player state on i_Start, then walks
// every player-bullet/enemy pair and every enemy-bullet/player pair, one pair per clock.
module bullet_hit_detector #(
    parameter int MAX_ENEMY            = 15,
    parameter int MAX_ENEMY_BULLET_SET = 2,
    parameter int MAX_PLAYER_BULLET    = 16,
    parameter int BULLET_WIDTH         = 6,
    parameter int BULLET_HEIGHT        = 20,
    parameter int ENEMY_WIDTH          = 36,
    parameter int ENEMY_HEIGHT         = 30,
    parameter int PLAYER_WIDTH         = 36,
    parameter int PLAYER_HEIGHT        = 30
) (
    input  logic                                       i_Clk,
    input  logic                                       i_Rst,
    input  logic                                       i_Start,
    input  logic [MAX_ENEMY-1:0]                       i_EnemyState,
    input  logic [19*MAX_ENEMY-1:0]                    i_EnemyPos,
    input  logic [MAX_ENEMY*MAX_ENEMY_BULLET_SET-1:0]  i_EnemyBulletState,
    input  logic [19*MAX_ENEMY*MAX_ENEMY_BULLET_SET-1:0] i_EnemyBulletPos,
    input  logic [MAX_PLAYER_BULLET-1:0]               i_PlayerBulletState,
    input  logic [19*MAX_PLAYER_BULLET-1:0]            i_PlayerBulletPos,
    input  logic [18:0]                                i_PlayerPos,
    output logic                                       o_Busy,
    output logic                                       o_Done,
    output logic [MAX_ENEMY-1:0]                       o_EnemyKill,
    output logic [MAX_PLAYER_BULLET-1:0]               o_PlayerBulletConsume,
    output logic [MAX_ENEMY*MAX_ENEMY_BULLET_SET-1:0]  o_EnemyBulletConsume,
    output logic                                       o_PlayerHit
);

    localparam int NumEnemyBullet = MAX_ENEMY * MAX_ENEMY_BULLET_SET;
    localparam int BulletIdxW     = (MAX_PLAYER_BULLET > 1) ? $clog2(MAX_PLAYER_BULLET) : 1;
    localparam int EnemyIdxW      = (MAX_ENEMY > 1) ? $clog2(MAX_ENEMY) : 1;
    localparam int EbIdxW         = (NumEnemyBullet > 1) ? $clog2(NumEnemyBullet) : 1;

    localparam logic [10:0] BulletW = 11'(BULLET_WIDTH);
    localparam logic [10:0] BulletH = 11'(BULLET_HEIGHT);
    localparam logic [10:0] EnemyW  = 11'(ENEMY_WIDTH);
    localparam logic [10:0] EnemyH  = 11'(ENEMY_HEIGHT);
    localparam logic [10:0] PlayerW = 11'(PLAYER_WIDTH);
    localparam logic [10:0] PlayerH = 11'(PLAYER_HEIGHT);

    typedef enum logic [1:0] {IDLE, SCAN_P, SCAN_E, DONE} state_t;

    state_t state, nextState;

    logic [MAX_ENEMY-1:0]         snapEnemyState;
    logic [18:0]                  snapEnemyPos [MAX_ENEMY];
    logic [NumEnemyBullet-1:0]    snapEbState;
    logic [18:0]                  snapEbPos [NumEnemyBullet];
    logic [MAX_PLAYER_BULLET-1:0] snapPbState;
    logic [18:0]                  snapPbPos [MAX_PLAYER_BULLET];
    logic [18:0]                  snapPlayerPos;

    logic [BulletIdxW-1:0] bulletIdx;
    logic [EnemyIdxW-1:0]  enemyIdx;
    logic [EbIdxW-1:0]     ebIdx;

    logic lastBullet, lastEnemy, lastEb, pairHit, ebHit;

    // Widened to 11 bits so a box near the right/bottom edge never wraps past zero.
    function automatic logic boxOverlap(input logic [18:0] aPos, input logic [10:0] aW,
                                        input logic [10:0] aH, input logic [18:0] bPos,
                                        input logic [10:0] bW, input logic [10:0] bH);
        logic [10:0] ax, ay, bx, by;
        ax = {1'b0, aPos[18:9]};
        ay = {2'b0, aPos[8:0]};
        bx = {1'b0, bPos[18:9]};
        by = {2'b0, bPos[8:0]};
        return (ax < bx + bW) && (bx < ax + aW) && (ay < by + bH) && (by < ay + aH);
    endfunction

    always_comb begin
        lastBullet = (bulletIdx == BulletIdxW'(MAX_PLAYER_BULLET - 1));
        lastEnemy  = (enemyIdx == EnemyIdxW'(MAX_ENEMY - 1));
        lastEb     = (ebIdx == EbIdxW'(NumEnemyBullet - 1));
        pairHit    = snapPbState[bulletIdx] && snapEnemyState[enemyIdx]
                     && !o_PlayerBulletConsume[bulletIdx] && !o_EnemyKill[enemyIdx]
                     && boxOverlap(snapPbPos[bulletIdx], BulletW, BulletH,
                                   snapEnemyPos[enemyIdx], EnemyW, EnemyH);
        ebHit      = snapEbState[ebIdx]
                     && boxOverlap(snapEbPos[ebIdx], BulletW, BulletH,
                                   snapPlayerPos, PlayerW, PlayerH);
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        o_Busy    = 1'b0;
        o_Done    = 1'b0;
        case (state)
            IDLE:   if (i_Start) nextState = SCAN_P;
            SCAN_P: begin
                o_Busy = 1'b1;
                if (lastBullet && lastEnemy) nextState = SCAN_E;
            end
            SCAN_E: begin
                o_Busy = 1'b1;
                if (lastEb) nextState = DONE;
            end
            DONE: begin
                o_Done    = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            snapEnemyState        <= '0;
            snapEbState           <= '0;
            snapPbState           <= '0;
            snapPlayerPos         <= '0;
            for (int n = 0; n < MAX_ENEMY; n++)         snapEnemyPos[n] <= '0;
            for (int n = 0; n < NumEnemyBullet; n++)    snapEbPos[n]    <= '0;
            for (int n = 0; n < MAX_PLAYER_BULLET; n++) snapPbPos[n]    <= '0;
            bulletIdx             <= '0;
            enemyIdx              <= '0;
            ebIdx                 <= '0;
            o_EnemyKill           <= '0;
            o_PlayerBulletConsume <= '0;
            o_EnemyBulletConsume  <= '0;
            o_PlayerHit           <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_Start) begin
                    snapEnemyState <= i_EnemyState;
                    snapEbState    <= i_EnemyBulletState;
                    snapPbState    <= i_PlayerBulletState;
                    snapPlayerPos  <= i_PlayerPos;
                    for (int n = 0; n < MAX_ENEMY; n++)
                        snapEnemyPos[n] <= i_EnemyPos[19*n +: 19];
                    for (int n = 0; n < NumEnemyBullet; n++)
                        snapEbPos[n] <= i_EnemyBulletPos[19*n +: 19];
                    for (int n = 0; n < MAX_PLAYER_BULLET; n++)
                        snapPbPos[n] <= i_PlayerBulletPos[19*n +: 19];
                    bulletIdx             <= '0;
                    enemyIdx              <= '0;
                    ebIdx                 <= '0;
                    o_EnemyKill           <= '0;
                    o_PlayerBulletConsume <= '0;
                    o_EnemyBulletConsume  <= '0;
                    o_PlayerHit           <= 1'b0;
                end
                SCAN_P: begin
                    if (pairHit) begin
                        o_EnemyKill[enemyIdx]            <= 1'b1;
                        o_PlayerBulletConsume[bulletIdx] <= 1'b1;
                    end
                    // Enemy is the inner loop; bullet advances when the enemy index wraps.
                    if (lastEnemy) begin
                        enemyIdx  <= '0;
                        bulletIdx <= lastBullet ? '0 : bulletIdx + 1'b1;
                    end else begin
                        enemyIdx <= enemyIdx + 1'b1;
                    end
                end
                SCAN_E: begin
                    if (ebHit) begin
                        o_EnemyBulletConsume[ebIdx] <= 1'b1;
                        o_PlayerHit                 <= 1'b1;
                    end
                    ebIdx <= lastEb ? '0 : ebIdx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_hit_detector.sv
// Scoreboard bench for bullet_hit_detector: directed scans push expected masks, a monitor
// checks them (plus done timing and busy length) whenever o_Done fires.
module tb_bullet_hit_detector;

    localparam int NE = 15;
    localparam int NS = 2;
    localparam int NP = 16;
    localparam int NK = NE * NS;
    localparam int LAT = NP * NE + NK;

    logic               i_Clk = 1'b0;
    logic               i_Rst = 1'b0;
    logic               i_Start = 1'b0;
    logic [NE-1:0]      enemyState;
    logic [19*NE-1:0]   enemyPos;
    logic [NK-1:0]      ebState;
    logic [19*NK-1:0]   ebPos;
    logic [NP-1:0]      pbState;
    logic [19*NP-1:0]   pbPos;
    logic [18:0]        playerPos;
    logic               o_Busy, o_Done, o_PlayerHit;
    logic [NE-1:0]      o_EnemyKill;
    logic [NP-1:0]      o_PlayerBulletConsume;
    logic [NK-1:0]      o_EnemyBulletConsume;

    bullet_hit_detector dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start),
        .i_EnemyState(enemyState), .i_EnemyPos(enemyPos),
        .i_EnemyBulletState(ebState), .i_EnemyBulletPos(ebPos),
        .i_PlayerBulletState(pbState), .i_PlayerBulletPos(pbPos),
        .i_PlayerPos(playerPos),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_EnemyKill(o_EnemyKill),
        .o_PlayerBulletConsume(o_PlayerBulletConsume),
        .o_EnemyBulletConsume(o_EnemyBulletConsume), .o_PlayerHit(o_PlayerHit)
    );

    always #5 i_Clk = ~i_Clk;

    int cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    typedef struct {
        int            doneCyc;
        logic [NE-1:0] kill;
        logic [NP-1:0] pbc;
        logic [NK-1:0] ebc;
        logic          phit;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   checks = 0;
    int   passes = 0;
    int   busyCnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge i_Clk) begin
        if (!i_Rst) begin
            busyCnt = 0;
        end else begin
            if (o_Busy) busyCnt++;
            if (o_Done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got o_Done=1, want no done (cycle %0d)", cyc);
                end else begin
                    cur = sbq.pop_front();
                    check("done_cycle", 64'(cyc), 64'(cur.doneCyc));
                    check("busy_cycles", 64'(busyCnt), 64'(LAT));
                    check("enemy_kill", 64'(o_EnemyKill), 64'(cur.kill));
                    check("pb_consume", 64'(o_PlayerBulletConsume), 64'(cur.pbc));
                    check("eb_consume", 64'(o_EnemyBulletConsume), 64'(cur.ebc));
                    check("player_hit", 64'(o_PlayerHit), 64'(cur.phit));
                end
                busyCnt = 0;
            end
        end
    end

    function automatic logic [18:0] pos(input int x, input int y);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        return {xv[9:0], yv[8:0]};
    endfunction

    task automatic clearInputs();
        enemyState = '0; enemyPos = '1;
        ebState    = '0; ebPos    = '1;
        pbState    = '0; pbPos    = '1;
        playerPos  = pos(500, 400);
    endtask

    task automatic setEnemy(input int n, input int x, input int y);
        enemyState[n] = 1'b1;
        enemyPos[19*n +: 19] = pos(x, y);
    endtask

    task automatic setPb(input int n, input int x, input int y);
        pbState[n] = 1'b1;
        pbPos[19*n +: 19] = pos(x, y);
    endtask

    task automatic setEb(input int n, input int x, input int y, input logic act);
        ebState[n] = act;
        ebPos[19*n +: 19] = pos(x, y);
    endtask

    task automatic startScan(input logic push, input logic [NE-1:0] kill,
                             input logic [NP-1:0] pbc, input logic [NK-1:0] ebc,
                             input logic phit, output int sc);
        exp_t e;
        @(negedge i_Clk);
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        sc = cyc;
        if (push) begin
            e.doneCyc = sc + LAT;
            e.kill = kill; e.pbc = pbc; e.ebc = ebc; e.phit = phit;
            sbq.push_back(e);
        end
    endtask

    task automatic waitDone();
        int n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge i_Clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            $display("FAIL done_timeout: got %0d pending results, want 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic runScan(input logic [NE-1:0] kill, input logic [NP-1:0] pbc,
                           input logic [NK-1:0] ebc, input logic phit);
        int sc;
        startScan(1'b1, kill, pbc, ebc, phit, sc);
        waitDone();
        @(negedge i_Clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        clearInputs();
        repeat (3) @(negedge i_Clk);
        check("reset_busy", 64'(o_Busy), 0);
        check("reset_done", 64'(o_Done), 0);
        check("reset_kill", 64'(o_EnemyKill), 0);
        check("reset_pbc", 64'(o_PlayerBulletConsume), 0);
        check("reset_ebc", 64'(o_EnemyBulletConsume), 0);
        check("reset_phit", 64'(o_PlayerHit), 0);
        i_Rst = 1'b1;
        @(negedge i_Clk);

        // Direct hit
        clearInputs(); setEnemy(7, 302, 108); setPb(0, 302, 108);
        runScan(15'h0080, 16'h0001, '0, 1'b0);

        // Vertical edge: touching is not overlap
        clearInputs(); setEnemy(7, 302, 108); setPb(0, 302, 138);
        runScan('0, '0, '0, 1'b0);
        clearInputs(); setEnemy(7, 302, 108); setPb(0, 302, 137);
        runScan(15'h0080, 16'h0001, '0, 1'b0);

        // Horizontal edge
        clearInputs(); setEnemy(7, 302, 108); setPb(0, 338, 108);
        runScan('0, '0, '0, 1'b0);
        clearInputs(); setEnemy(7, 302, 108); setPb(0, 337, 108);
        runScan(15'h0080, 16'h0001, '0, 1'b0);

        // Two bullets on one enemy: only the first is consumed; dead enemy is never hit
        clearInputs(); setEnemy(7, 302, 108); setPb(0, 302, 108); setPb(3, 302, 108);
        runScan(15'h0080, 16'h0001, '0, 1'b0);
        clearInputs(); setEnemy(7, 302, 108); enemyState[7] = 1'b0;
        setPb(0, 302, 108); setPb(3, 302, 108);
        runScan('0, '0, '0, 1'b0);

        // Overlapping enemies: bullet 0 takes enemy 2, bullet 1 takes enemy 3, bullet 2 spare
        clearInputs(); setEnemy(2, 100, 50); setEnemy(3, 120, 50);
        setPb(0, 125, 60); setPb(1, 125, 60); setPb(2, 125, 60);
        runScan(15'h000C, 16'h0003, '0, 1'b0);

        // Far corner: sums exceed 10/9 bits
        clearInputs(); setEnemy(14, 1000, 480); setPb(15, 1020, 500);
        runScan(15'h4000, 16'h8000, '0, 1'b0);

        // Enemy bullets on the player: every overlapping active one is consumed
        clearInputs(); playerPos = pos(302, 372);
        setEb(5, 302, 372, 1'b1); setEb(6, 310, 380, 1'b1); setEb(7, 302, 372, 1'b0);
        runScan('0, '0, 30'h60, 1'b1);

        // Input changes and start pulses during a scan and during DONE are ignored
        clearInputs(); setEnemy(7, 302, 108); setPb(0, 302, 108);
        startScan(1'b1, 15'h0080, 16'h0001, '0, 1'b0, sc);
        repeat (100) @(negedge i_Clk);
        clearInputs(); setEnemy(3, 10, 10); setPb(5, 10, 10); playerPos = pos(0, 0);
        setEb(0, 0, 0, 1'b1);
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        repeat (LAT - 101) @(negedge i_Clk);
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        check("start_in_done_busy", 64'(o_Busy), 0);
        @(negedge i_Clk);
        check("start_in_done_busy2", 64'(o_Busy), 0);
        waitDone();

        // Reset mid-scan aborts with no done, then a fresh scan completes
        clearInputs(); setEnemy(7, 302, 108); setPb(0, 302, 108);
        startScan(1'b0, '0, '0, '0, 1'b0, sc);
        repeat (50) @(negedge i_Clk);
        check("pre_reset_kill", 64'(o_EnemyKill), 64'h0080);
        i_Rst = 1'b0;
        #1;
        check("abort_busy", 64'(o_Busy), 0);
        check("abort_done", 64'(o_Done), 0);
        check("abort_kill", 64'(o_EnemyKill), 0);
        check("abort_pbc", 64'(o_PlayerBulletConsume), 0);
        repeat (3) @(negedge i_Clk);
        i_Rst = 1'b1;
        repeat (300) @(negedge i_Clk);
        check("abort_idle_busy", 64'(o_Busy), 0);
        runScan(15'h0080, 16'h0001, '0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
